// File: rtl/dm_access_ctrl.sv
// Data-memory access controller: byte-aligns load/store requests onto a word-wide DM port,
// performs sub-word stores as read-modify-write, and reports alignment/range faults.
module dm_access_ctrl #(
  parameter logic [31:0] DM_BYTES = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_exc,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_pc,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  state_t      state;
  logic [2:0]  op_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;

  logic        misaligned;
  logic        out_of_range;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_val;
  logic [31:0] merged;

  // Fault classification of the request currently offered on the port.
  always_comb begin
    misaligned = 1'b0;
    if ((req_op == OP_LW || req_op == OP_SW) && req_addr[1:0] != 2'b00)
      misaligned = 1'b1;
    if ((req_op == OP_LH || req_op == OP_LHU || req_op == OP_SH) && req_addr[0])
      misaligned = 1'b1;
    out_of_range = (req_addr >= DM_BYTES);
  end

  // Lane extraction for loads and lane merge for sub-word stores, little-endian.
  always_comb begin
    byte_lane = 8'h00;
    load_val  = 32'h0;
    merged    = mem_rdata;
    case (lane_q)
      2'd0:    byte_lane = mem_rdata[7:0];
      2'd1:    byte_lane = mem_rdata[15:8];
      2'd2:    byte_lane = mem_rdata[23:16];
      default: byte_lane = mem_rdata[31:24];
    endcase
    half_lane = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (op_q)
      OP_LW:   load_val = mem_rdata;
      OP_LH:   load_val = {{16{half_lane[15]}}, half_lane};
      OP_LHU:  load_val = {16'h0000, half_lane};
      OP_LB:   load_val = {{24{byte_lane[7]}}, byte_lane};
      OP_LBU:  load_val = {24'h000000, byte_lane};
      default: load_val = 32'h0;
    endcase
    if (op_q == OP_SB) begin
      case (lane_q)
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else if (op_q == OP_SH) begin
      if (lane_q[1])
        merged[31:16] = wdata_q;
      else
        merged[15:0] = wdata_q;
    end
  end

  // Single FSM with all outputs registered; strobes default low each cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_exc   <= 1'b0;
      mem_addr   <= 32'h0;
      mem_we     <= 1'b0;
      mem_wdata  <= 32'h0;
      mem_pc     <= 32'h0;
      op_q       <= OP_LW;
      lane_q     <= 2'b00;
      wdata_q    <= 16'h0;
    end else begin
      resp_valid <= 1'b0;
      mem_we     <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q      <= req_op;
            lane_q    <= req_addr[1:0];
            wdata_q   <= req_wdata[15:0];
            mem_addr  <= {req_addr[31:2], 2'b00};
            mem_pc    <= req_pc;
            req_ready <= 1'b0;
            if (misaligned || out_of_range) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_exc   <= 1'b1;
              resp_rdata <= 32'h0;
            end else if (req_op == OP_SW) begin
              state     <= WRITE;
              mem_we    <= 1'b1;
              mem_wdata <= req_wdata;
            end else if (req_op == OP_SH || req_op == OP_SB) begin
              state <= RMW_RD;
            end else begin
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_exc   <= 1'b0;
          resp_rdata <= load_val;
        end
        RMW_RD: begin
          state     <= WRITE;
          mem_we    <= 1'b1;
          mem_wdata <= merged;
        end
        WRITE: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_exc   <= 1'b0;
          resp_rdata <= 32'h0;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          mem_addr  <= 32'h0;
          mem_pc    <= 32'h0;
        end
      endcase
    end
  end

endmodule
